// File: rtl/vdp_pkg.sv
// Shared VDP constants: CPU port selects, access codes, prefetch states.
// Imported by the CPU port block and the register-file block.
package vdp_pkg;

    localparam logic       PORT_DATA    = 1'b0;
    localparam logic       PORT_CTRL    = 1'b1;

    localparam logic [1:0] CODE_VRAM_RD = 2'd0;
    localparam logic [1:0] CODE_VRAM_WR = 2'd1;
    localparam logic [1:0] CODE_REG_WR  = 2'd2;
    localparam logic [1:0] CODE_CRAM_WR = 2'd3;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_REQ  = 2'd1,
        PF_CAPT = 2'd2
    } pf_state_t;

endpackage

// File: rtl/vdp_cpu_port.sv
// VDP CPU port: decodes Z80 data/control port accesses into VRAM,
// CRAM and register writes, plus the VRAM read-ahead prefetch.
module vdp_cpu_port
    import vdp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_port,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic [7:0]  status_in,
    output logic        status_clear,
    output logic        vram_we,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic        cram_we,
    output logic [4:0]  cram_waddr,
    output logic [11:0] cram_wdata,
    output logic        reg_we,
    output logic [3:0]  reg_addr,
    output logic [7:0]  reg_data,
    output logic        busy
);

    logic [13:0] addr_q, addr_d;
    logic [1:0]  code_q, code_d;
    logic        second_q, second_d;
    logic [7:0]  first_q, first_d;
    logic [7:0]  read_buf_q, read_buf_d;
    logic [7:0]  cram_latch_q, cram_latch_d;
    pf_state_t   state_q, state_d;

    logic [7:0]  dout_q, dout_d;
    logic        status_clear_q, status_clear_d;
    logic        vram_we_q, vram_we_d;
    logic [13:0] vram_addr_q, vram_addr_d;
    logic [7:0]  vram_wdata_q, vram_wdata_d;
    logic        cram_we_q, cram_we_d;
    logic [4:0]  cram_waddr_q, cram_waddr_d;
    logic [11:0] cram_wdata_q, cram_wdata_d;
    logic        reg_we_q, reg_we_d;
    logic [3:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_data_q, reg_data_d;

    logic        wr;
    logic        rd;
    logic        pf_start;
    logic [13:0] pf_addr;
    logic [13:0] new_addr;

    assign wr       = cpu_we;
    assign rd       = cpu_re & ~cpu_we;
    assign new_addr = {cpu_din[5:0], first_q};

    always_comb begin
        addr_d         = addr_q;
        code_d         = code_q;
        second_d       = second_q;
        first_d        = first_q;
        read_buf_d     = read_buf_q;
        cram_latch_d   = cram_latch_q;
        state_d        = state_q;
        dout_d         = dout_q;
        status_clear_d = 1'b0;
        vram_we_d      = 1'b0;
        vram_addr_d    = vram_addr_q;
        vram_wdata_d   = vram_wdata_q;
        cram_we_d      = 1'b0;
        cram_waddr_d   = cram_waddr_q;
        cram_wdata_d   = cram_wdata_q;
        reg_we_d       = 1'b0;
        reg_addr_d     = reg_addr_q;
        reg_data_d     = reg_data_q;
        pf_start       = 1'b0;
        pf_addr        = addr_q;

        if (wr && cpu_port == PORT_CTRL) begin
            if (!second_q) begin
                first_d  = cpu_din;
                second_d = 1'b1;
            end else begin
                code_d   = cpu_din[7:6];
                addr_d   = new_addr;
                second_d = 1'b0;
                case (cpu_din[7:6])
                    CODE_VRAM_RD: begin
                        pf_start = 1'b1;
                        pf_addr  = new_addr;
                    end
                    CODE_REG_WR: begin
                        reg_we_d   = 1'b1;
                        reg_addr_d = cpu_din[3:0];
                        reg_data_d = first_q;
                    end
                    default: ;
                endcase
            end
        end else if (wr) begin
            second_d   = 1'b0;
            read_buf_d = cpu_din;
            addr_d     = addr_q + 14'd1;
            if (code_q != CODE_CRAM_WR) begin
                vram_we_d    = 1'b1;
                vram_addr_d  = addr_q;
                vram_wdata_d = cpu_din;
            end else if (!addr_q[0]) begin
                cram_latch_d = cpu_din;
            end else begin
                cram_we_d    = 1'b1;
                cram_waddr_d = addr_q[5:1];
                cram_wdata_d = {cpu_din[3:0], cram_latch_q};
            end
        end else if (rd && cpu_port == PORT_CTRL) begin
            dout_d         = status_in;
            status_clear_d = 1'b1;
            second_d       = 1'b0;
        end else if (rd) begin
            dout_d   = read_buf_q;
            second_d = 1'b0;
            pf_start = 1'b1;
            pf_addr  = addr_q;
        end

        // An in-flight prefetch always finishes; a new start is dropped.
        case (state_q)
            PF_IDLE: begin
                if (pf_start) begin
                    state_d     = PF_REQ;
                    vram_addr_d = pf_addr;
                end
            end
            PF_REQ: begin
                state_d = PF_CAPT;
            end
            PF_CAPT: begin
                read_buf_d = vram_rdata;
                addr_d     = addr_q + 14'd1;
                state_d    = PF_IDLE;
            end
            default: begin
                state_d = PF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q         <= '0;
            code_q         <= '0;
            second_q       <= 1'b0;
            first_q        <= '0;
            read_buf_q     <= '0;
            cram_latch_q   <= '0;
            state_q        <= PF_IDLE;
            dout_q         <= '0;
            status_clear_q <= 1'b0;
            vram_we_q      <= 1'b0;
            vram_addr_q    <= '0;
            vram_wdata_q   <= '0;
            cram_we_q      <= 1'b0;
            cram_waddr_q   <= '0;
            cram_wdata_q   <= '0;
            reg_we_q       <= 1'b0;
            reg_addr_q     <= '0;
            reg_data_q     <= '0;
        end else begin
            addr_q         <= addr_d;
            code_q         <= code_d;
            second_q       <= second_d;
            first_q        <= first_d;
            read_buf_q     <= read_buf_d;
            cram_latch_q   <= cram_latch_d;
            state_q        <= state_d;
            dout_q         <= dout_d;
            status_clear_q <= status_clear_d;
            vram_we_q      <= vram_we_d;
            vram_addr_q    <= vram_addr_d;
            vram_wdata_q   <= vram_wdata_d;
            cram_we_q      <= cram_we_d;
            cram_waddr_q   <= cram_waddr_d;
            cram_wdata_q   <= cram_wdata_d;
            reg_we_q       <= reg_we_d;
            reg_addr_q     <= reg_addr_d;
            reg_data_q     <= reg_data_d;
        end
    end

    assign cpu_dout     = dout_q;
    assign status_clear = status_clear_q;
    assign vram_we      = vram_we_q;
    assign vram_addr    = vram_addr_q;
    assign vram_wdata   = vram_wdata_q;
    assign cram_we      = cram_we_q;
    assign cram_waddr   = cram_waddr_q;
    assign cram_wdata   = cram_wdata_q;
    assign reg_we       = reg_we_q;
    assign reg_addr     = reg_addr_q;
    assign reg_data     = reg_data_q;
    assign busy         = (state_q != PF_IDLE);

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a small VRAM model on port B.
// Each scenario task drives strobes and checks outputs at negedge.
module tb_vdp_cpu_port;

    logic        clk;
    logic        rst;
    logic        cpu_port;
    logic        cpu_we;
    logic        cpu_re;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic [7:0]  status_in;
    logic        status_clear;
    logic        vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic        cram_we;
    logic [4:0]  cram_waddr;
    logic [11:0] cram_wdata;
    logic        reg_we;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        busy;

    int n_chk;
    int n_pass;

    logic [7:0] mem [0:16383];

    vdp_cpu_port dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_port     (cpu_port),
        .cpu_we       (cpu_we),
        .cpu_re       (cpu_re),
        .cpu_din      (cpu_din),
        .cpu_dout     (cpu_dout),
        .status_in    (status_in),
        .status_clear (status_clear),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_wdata   (vram_wdata),
        .vram_rdata   (vram_rdata),
        .cram_we      (cram_we),
        .cram_waddr   (cram_waddr),
        .cram_wdata   (cram_wdata),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous VRAM: read data valid one cycle after the address.
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    // Strobe for one cycle; returns at the negedge after the sampling edge.
    task automatic cpu_wr(input logic port, input logic [7:0] d);
        @(negedge clk);
        cpu_port = port;
        cpu_din  = d;
        cpu_we   = 1'b1;
        @(negedge clk);
        cpu_we   = 1'b0;
    endtask

    task automatic cpu_rd(input logic port);
        @(negedge clk);
        cpu_port = port;
        cpu_re   = 1'b1;
        @(negedge clk);
        cpu_re   = 1'b0;
    endtask

    task automatic gap();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({cpu_dout, status_clear, vram_we, vram_addr, vram_wdata,
             cram_we, cram_waddr, cram_wdata, reg_we, reg_addr,
             reg_data, busy} !== '0)
            $display("FAIL reset_outputs dout=%h vaddr=%h busy=%b want all 0",
                     cpu_dout, vram_addr, busy);
        else n_pass++;
    endtask

    task automatic test_vram_write();
        cpu_wr(1'b1, 8'h00); gap();
        cpu_wr(1'b1, 8'h40); gap();
        cpu_wr(1'b0, 8'hAA);
        n_chk++;
        if ({vram_we, vram_addr, vram_wdata} !== {1'b1, 14'h0000, 8'hAA})
            $display("FAIL vwr0 we=%b addr=%h data=%h want 1 0000 aa",
                     vram_we, vram_addr, vram_wdata);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (vram_we !== 1'b0)
            $display("FAIL vwr_pulse we=%b want 0", vram_we);
        else n_pass++;
        repeat (2) @(negedge clk);
        cpu_wr(1'b0, 8'h55);
        n_chk++;
        if ({vram_we, vram_addr, vram_wdata} !== {1'b1, 14'h0001, 8'h55})
            $display("FAIL vwr1 we=%b addr=%h data=%h want 1 0001 55",
                     vram_we, vram_addr, vram_wdata);
        else n_pass++;
        gap();
        cpu_wr(1'b0, 8'h77);
        n_chk++;
        if ({vram_we, vram_addr} !== {1'b1, 14'h0002})
            $display("FAIL vwr_next we=%b addr=%h want 1 0002",
                     vram_we, vram_addr);
        else n_pass++;
        gap();
        n_chk++;
        if (mem[1] !== 8'h55)
            $display("FAIL vwr_mem got=%h want 55", mem[1]);
        else n_pass++;
    endtask

    task automatic test_reg_write();
        cpu_wr(1'b1, 8'h34); gap();
        cpu_wr(1'b1, 8'h81);
        n_chk++;
        if ({reg_we, reg_addr, reg_data, vram_we} !== {1'b1, 4'h1, 8'h34, 1'b0})
            $display("FAIL regwr we=%b addr=%h data=%h vwe=%b want 1 1 34 0",
                     reg_we, reg_addr, reg_data, vram_we);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (reg_we !== 1'b0)
            $display("FAIL regwr_pulse we=%b want 0", reg_we);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_vram_read();
        logic [7:0] exp [0:2];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        mem[16'h10] = 8'h11;
        mem[16'h11] = 8'h22;
        mem[16'h12] = 8'h33;
        cpu_wr(1'b1, 8'h10); gap();
        cpu_wr(1'b1, 8'h00);
        n_chk++;
        if ({busy, vram_addr} !== {1'b1, 14'h0010})
            $display("FAIL rd_setup busy=%b addr=%h want 1 0010",
                     busy, vram_addr);
        else n_pass++;
        gap();
        for (int i = 0; i < 3; i++) begin
            cpu_rd(1'b0);
            n_chk++;
            if ({cpu_dout, busy} !== {exp[i], 1'b1})
                $display("FAIL rd%0d dout=%h busy=%b want %h 1",
                         i, cpu_dout, busy, exp[i]);
            else n_pass++;
            @(negedge clk);
            n_chk++;
            if (busy !== 1'b1)
                $display("FAIL rd%0d_busy2 busy=%b want 1", i, busy);
            else n_pass++;
            @(negedge clk);
            n_chk++;
            if (busy !== 1'b0)
                $display("FAIL rd%0d_idle busy=%b want 0", i, busy);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_cram_write();
        cpu_wr(1'b1, 8'h06); gap();
        cpu_wr(1'b1, 8'hC0); gap();
        cpu_wr(1'b0, 8'hE4);
        n_chk++;
        if ({cram_we, vram_we} !== 2'b00)
            $display("FAIL cram_even cwe=%b vwe=%b want 0 0", cram_we, vram_we);
        else n_pass++;
        gap();
        cpu_wr(1'b0, 8'h0F);
        n_chk++;
        if ({cram_we, cram_waddr, cram_wdata, vram_we}
                !== {1'b1, 5'd3, 12'hFE4, 1'b0})
            $display("FAIL cram_odd we=%b idx=%h data=%h vwe=%b want 1 03 fe4 0",
                     cram_we, cram_waddr, cram_wdata, vram_we);
        else n_pass++;
        gap();
    endtask

    task automatic test_wrap();
        cpu_wr(1'b1, 8'hFF); gap();
        cpu_wr(1'b1, 8'h7F); gap();
        cpu_wr(1'b0, 8'h01);
        n_chk++;
        if ({vram_we, vram_addr, vram_wdata} !== {1'b1, 14'h3FFF, 8'h01})
            $display("FAIL wrap_hi we=%b addr=%h data=%h want 1 3fff 01",
                     vram_we, vram_addr, vram_wdata);
        else n_pass++;
        gap();
        cpu_wr(1'b0, 8'h02);
        n_chk++;
        if ({vram_we, vram_addr, vram_wdata} !== {1'b1, 14'h0000, 8'h02})
            $display("FAIL wrap_lo we=%b addr=%h data=%h want 1 0000 02",
                     vram_we, vram_addr, vram_wdata);
        else n_pass++;
        gap();
        n_chk++;
        if (mem[16383] !== 8'h01)
            $display("FAIL wrap_mem got=%h want 01", mem[16383]);
        else n_pass++;
    endtask

    task automatic test_status_read();
        status_in = 8'hA5;
        cpu_wr(1'b1, 8'h12); gap();
        cpu_rd(1'b1);
        n_chk++;
        if ({status_clear, cpu_dout} !== {1'b1, 8'hA5})
            $display("FAIL status clr=%b dout=%h want 1 a5",
                     status_clear, cpu_dout);
        else n_pass++;
        status_in = 8'h00;
        @(negedge clk);
        n_chk++;
        if ({status_clear, cpu_dout} !== {1'b0, 8'hA5})
            $display("FAIL status_hold clr=%b dout=%h want 0 a5",
                     status_clear, cpu_dout);
        else n_pass++;
        repeat (2) @(negedge clk);
        cpu_wr(1'b1, 8'h00); gap();
        cpu_wr(1'b1, 8'h40); gap();
        cpu_wr(1'b0, 8'h99);
        n_chk++;
        if ({vram_we, vram_addr, vram_wdata} !== {1'b1, 14'h0000, 8'h99})
            $display("FAIL flag_reset we=%b addr=%h data=%h want 1 0000 99",
                     vram_we, vram_addr, vram_wdata);
        else n_pass++;
        gap();
    endtask

    task automatic test_we_re_together();
        // addr is 0x0001 with code 1 after the previous scenario
        @(negedge clk);
        cpu_port = 1'b0;
        cpu_din  = 8'h3C;
        cpu_we   = 1'b1;
        cpu_re   = 1'b1;
        @(negedge clk);
        cpu_we   = 1'b0;
        cpu_re   = 1'b0;
        n_chk++;
        if ({vram_we, vram_addr, vram_wdata, busy, cpu_dout}
                !== {1'b1, 14'h0001, 8'h3C, 1'b0, 8'hA5})
            $display("FAIL we_re we=%b addr=%h data=%h busy=%b dout=%h want 1 0001 3c 0 a5",
                     vram_we, vram_addr, vram_wdata, busy, cpu_dout);
        else n_pass++;
        gap();
    endtask

    task automatic test_reset_mid_prefetch();
        mem[16'h0200] = 8'h5A;
        cpu_wr(1'b1, 8'h00); gap();
        cpu_wr(1'b1, 8'h02);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if (busy !== 1'b0)
            $display("FAIL rst_mid busy=%b want 0", busy);
        else n_pass++;
        repeat (2) @(negedge clk);
        cpu_rd(1'b0);
        n_chk++;
        if (cpu_dout !== 8'h00)
            $display("FAIL rst_mid_buf dout=%h want 00", cpu_dout);
        else n_pass++;
        gap();
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        cpu_port  = 1'b0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        cpu_din   = 8'h00;
        status_in = 8'h00;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;

        test_reset();
        test_vram_write();
        test_reg_write();
        test_vram_read();
        test_cram_write();
        test_wrap();
        test_status_read();
        test_we_re_together();
        test_reset_mid_prefetch();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
